vert_avg_ctrl: RTL
==================

# vert_avg_ctrl

Sequencing controller for the vertical-averaging stage of the dynamic-resizing datapath. For each output row it runs two row loads into a ping-pong pair of 28-entry pixel buffers, then triggers the averaging/output stage to combine the pair. It repeats until a full frame of input rows has been consumed, then pulses `done`. It sits between the top-level resize FSM (`start`/`done`) and the row-input and averaging units, which are both req/ack slaves.

## Interface
- `ROWS_IN`, 28: input rows per frame; must be even and ≥2; output rows = `ROWS_IN/2`.
- `ROW_W`, 5: width of the `out_row` index; must be ≥ clog2(`ROWS_IN/2`).
- `clk` input 1: single clock; all logic on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle frame start; sampled only in IDLE.
- `busy` output 1: high from the cycle after an accepted `start` until the `done` cycle inclusive.
- `done` output 1: one-cycle pulse when the frame completes.
- `load_req` output 1: request to the row-input unit to fill one buffer.
- `load_ack` input 1: one-cycle completion pulse from the row-input unit.
- `load_sel` output 1: target buffer for the load; 0 = buffer A, 1 = buffer B. Stable while `load_req` is high.
- `avg_req` output 1: request to the averaging unit to combine A and B and emit one output row.
- `avg_ack` input 1: one-cycle completion pulse from the averaging unit.
- `out_row` output `ROW_W`: index of the output row being produced; stable while `avg_req` is high.

## Operation
- States: IDLE, LOAD_A, LOAD_B, AVG, REL_A, REL_B, REL_AVG.
- **IDLE:**
  - `start` clears the row counter and moves to LOAD_A.
  - `load_ack` and `avg_ack` are ignored.
- **LOAD_A:**
  - Drives `load_req`=1, `load_sel`=0.
  - On `load_ack`=1, moves to REL_A.
- **REL_A:** drives `load_req`=0 for exactly one cycle, then moves to LOAD_B.
- **LOAD_B:**
  - Drives `load_req`=1, `load_sel`=1.
  - On `load_ack`, moves to REL_B.
- **REL_B:** one cycle with both requests low, then moves to AVG.
- **AVG:**
  - Drives `avg_req`=1 with `out_row` = counter.
  - On `avg_ack`, moves to REL_AVG.
- **REL_AVG:**
  - If counter = `ROWS_IN/2`-1: pulse `done`, clear the counter, go to IDLE.
  - Otherwise: increment the counter and go to LOAD_A.
- Handshake rules (slave behaviour):
  - A slave asserts ack for exactly one cycle while req is high.
  - A slave clears ack on the cycle after it sees req low.
  - The REL states guarantee req is low for ≥1 cycle between transactions, so the slave's internal index resets before the next request.
- `load_req` and `avg_req` are never high in the same cycle.
- An ack arriving in a state that is not waiting on that unit is ignored. This covers `avg_ack` during a LOAD state and `load_ack` during AVG.
- `start` while busy is ignored; no queuing.
- No timeout: the controller waits in a request state indefinitely.

## Timing
- Reset values: `busy`=0, `done`=0, `load_req`=0, `load_sel`=0, `avg_req`=0, `out_row`=0, state=IDLE.
- All outputs are registered or decoded from registered state only; there are no combinational paths from any input to any output.
- `start` sampled at edge k → `load_req`=1 and `busy`=1 in cycle k+1.
- `load_ack` sampled at edge m → `load_req`=0 in cycle m+1 (REL), reasserted in cycle m+2.
- Overhead per output row: 3 controller cycles (REL states) plus 3 ack-sampling cycles, on top of the slave latencies.
- `done` is high in the REL_AVG cycle of the last row. `busy` falls in the next cycle together with the return to IDLE.
- Counter width is `ROW_W`; the final-row compare makes wrap impossible.
- Async reset mid-frame: all outputs clear immediately, independent of `clk`. On the first edge after release the state is IDLE, and a fresh `start` is required.
- Ack coincident with reset release is ignored, because the state is IDLE.

## Structure
- Shared resize package holds:
  - the state enum `vavg_state_t`;
  - `BUF_A`/`BUF_B` select constants;
  - `ROW_LEN`=28 and default `ROWS_IN`=28, also used by the row-input and averaging units.
- A single module with no sub-modules. A generic `req_ack_master` sub-module is not warranted for two channels; the REL states implement the release.

## Test plan
- Reset, then `start` with slaves that ack 30 cycles after req → 14 LOAD_A/LOAD_B/AVG triples. Check:
  - `out_row` = 0..13 in order, `load_sel` alternating 0,1;
  - exactly one `done` pulse, `busy` low the next cycle.
- Ack on the first cycle of req (zero-latency slave) → `load_req` low for exactly 1 cycle between loads, and never high together with `avg_req`.
- Spurious `avg_ack` during LOAD_A, and `load_ack` in IDLE → no state change, no `done`.
- `start` pulsed again mid-frame at row 5 → ignored; frame completes with 14 rows and one `done`.
- Assert `resetn`=0 during AVG at row 7 → all outputs 0 immediately. After release and a new `start`, `out_row` restarts at 0.
- `ROWS_IN`=2 → exactly one load pair and one AVG with `out_row`=0, then `done`.

Source files
------------

// File: rtl/vert_avg_ctrl_pkg.sv
// Shared definitions for the vertical-averaging stage of the resize datapath.
package vert_avg_ctrl_pkg;

  // Sequencer states; the REL_* states hold both requests low for one cycle
  // so each slave sees a release before its next transaction.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_REL_A   = 3'd2,
    ST_LOAD_B  = 3'd3,
    ST_REL_B   = 3'd4,
    ST_AVG     = 3'd5,
    ST_REL_AVG = 3'd6
  } vavg_state_t;

  // Ping-pong buffer select values carried on load_sel.
  localparam logic BUF_A = 1'b0;
  localparam logic BUF_B = 1'b1;

  // Pixels per buffered row and default input rows per frame; the row-input
  // and averaging units size themselves from these as well.
  localparam int ROW_LEN         = 28;
  localparam int ROWS_IN_DEFAULT = 28;

endpackage

// File: rtl/vert_avg_ctrl.sv
// Vertical-averaging sequencer: for each output row, load buffer A, load
// buffer B, then ask the averaging unit to combine them. Pulses done after
// ROWS_IN/2 output rows. All outputs come straight from flops.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   IDLE       | waiting for start, acks ignored
//   LOAD_A     | load_req=1, load_sel=A, waiting for load_ack
//   REL_A      | one cycle with load_req released
//   LOAD_B     | load_req=1, load_sel=B, waiting for load_ack
//   REL_B      | one cycle with both requests released
//   AVG        | avg_req=1, out_row=counter, waiting for avg_ack
//   REL_AVG    | release; last row pulses done, else next row
module vert_avg_ctrl
  import vert_avg_ctrl_pkg::*;
#(
  parameter int ROWS_IN = ROWS_IN_DEFAULT,
  parameter int ROW_W   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             load_req,
  input  logic             load_ack,
  output logic             load_sel,
  output logic             avg_req,
  input  logic             avg_ack,
  output logic [ROW_W-1:0] out_row
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS_IN / 2 - 1);

  vavg_state_t      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_req_q, load_req_d;
  logic             load_sel_q, load_sel_d;
  logic             avg_req_q, avg_req_d;

  // Next state, row counter, and the output values that go with the next state.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_A;
          row_d   = '0;
        end
      end
      ST_LOAD_A:  if (load_ack) state_d = ST_REL_A;
      ST_REL_A:   state_d = ST_LOAD_B;
      ST_LOAD_B:  if (load_ack) state_d = ST_REL_B;
      ST_REL_B:   state_d = ST_AVG;
      ST_AVG:     if (avg_ack) state_d = ST_REL_AVG;
      ST_REL_AVG: begin
        // Comparing against the last row before incrementing keeps the
        // counter from ever wrapping.
        if (row_q == LAST_ROW) begin
          state_d = ST_IDLE;
          row_d   = '0;
        end else begin
          state_d = ST_LOAD_A;
          row_d   = row_q + ROW_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    load_req_d = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
    load_sel_d = (state_d == ST_LOAD_B) ? BUF_B : BUF_A;
    avg_req_d  = (state_d == ST_AVG);
    busy_d     = (state_d != ST_IDLE);
    // Counter only moves on leaving REL_AVG, so row_q still names this row.
    done_d     = (state_d == ST_REL_AVG) && (row_q == LAST_ROW);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_req_q <= 1'b0;
      load_sel_q <= BUF_A;
      avg_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_req_q <= load_req_d;
      load_sel_q <= load_sel_d;
      avg_req_q  <= avg_req_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign load_req = load_req_q;
  assign load_sel = load_sel_q;
  assign avg_req  = avg_req_q;
  assign out_row  = row_q;

endmodule
